// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU among NREQ requesters, with registered operand issue.
// Optional sticky add/sub overflow error flag, enabled by defining ALU_ARB_STICKY_FLAG_EN.
module alu_share_arbiter #(
  parameter  int unsigned NREQ  = 2,
  parameter  int unsigned IDX_W = 1,
  localparam int unsigned DW    = 32,
  localparam int unsigned CW    = 4,
  localparam int unsigned SW    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [CW*NREQ-1:0] req_ctl,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
  input  logic [SW*NREQ-1:0] req_shamt,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_flag,
  output logic [CW-1:0]      alu_ctl,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [SW-1:0]      alu_shamt,
  input  logic [DW-1:0]      alu_out,
  input  logic               alu_ovf,
  output logic               flag_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic             pick_vld;
  logic             accept;

  // Round-robin search: first valid index after the last grant, wrapping.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(last) + k) % NREQ);
      if (!pick_vld && req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next state and the combinational accept handshake.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && !reset) begin
          req_ready[pick] = 1'b1;
          accept          = 1'b1;
          state_nxt       = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= IDX_W'(NREQ - 1);
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_flag  <= 1'b0;
      alu_ctl   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shamt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_ctl   <= req_ctl[CW*32'(pick) +: CW];
        alu_a     <= req_a[DW*32'(pick) +: DW];
        alu_b     <= req_b[DW*32'(pick) +: DW];
        alu_shamt <= req_shamt[SW*32'(pick) +: SW];
        grant     <= pick;
        last      <= pick;
      end
      if (state == ISSUE) begin
        rsp_data  <= alu_out;
        rsp_flag  <= alu_ovf;
        rsp_valid <= NREQ'(1) << grant;
      end else if (state == RESP && rsp_ready[grant]) begin
        rsp_valid <= '0;
      end
    end
  end

`ifdef ALU_ARB_STICKY_FLAG_EN
  logic flag_err_q;

  // Sticky: signed overflow on an add/sub code seen while the op is at the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_err_q <= 1'b0;
    end else if (state == ISSUE && alu_ovf &&
                 (alu_ctl == 4'b0010 || alu_ctl == 4'b0011 || alu_ctl == 4'b0110)) begin
      flag_err_q <= 1'b1;
    end
  end

  assign flag_err = flag_err_q;
`else
  assign flag_err = 1'b0;
`endif

endmodule
